// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO push arbiter.
package fifo_arb_pkg;

  typedef enum logic {IDLE, BURST} arb_state_t;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_QWID     = 2;
  localparam int DEF_MAX_WAIT = 16;
  localparam int MAX_NREQ     = 32;

  function automatic int wait_width(input int max_wait);
    return $clog2(max_wait + 1);
  endfunction

  function automatic logic [MAX_NREQ-1:0] onehot(input int idx);
    return MAX_NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Rotating-priority picker: first valid index at or after ptr, wrapping modulo NREQ.
module rr_select #(
  parameter int NREQ = 4,
  parameter int QWID = 2
) (
  input  logic [NREQ-1:0] vld,
  input  logic [QWID-1:0] ptr,
  output logic [QWID-1:0] winner,
  output logic            any
);

  logic [QWID-1:0] idx;

  // Scan from the farthest offset down so the offset closest to ptr wins last.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = ptr + QWID'(k);
      if (vld[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_push_arbiter.sv
// Packet-granular round-robin arbiter in front of a FIFO push port,
// with a per-requester starvation watchdog driving prop_signal.
module fifo_rr_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int QWID     = DEF_QWID,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [(1<<QWID)-1:0]       req_vld,
  input  logic [(1<<QWID)-1:0]       req_last,
  input  logic [(1<<QWID)*WIDTH-1:0] req_data,
  output logic [(1<<QWID)-1:0]       req_rdy,
  input  logic                      fifo_full,
  output logic                      fifo_push,
  output logic [WIDTH-1:0]          fifo_data,
  output logic [QWID-1:0]           fifo_qid,
  output logic                      busy,
  output logic                      prop_signal
);

  localparam int NREQ  = 1 << QWID;
  localparam int WAITW = wait_width(MAX_WAIT);

  arb_state_t      state;
  logic [QWID-1:0] owner;
  logic [QWID-1:0] rr_ptr;
  logic [QWID-1:0] sel_winner;
  logic [QWID-1:0] winner;
  logic            sel_any;
  logic            win_vld;
  logic            accept;
  logic            starve;
  logic [NREQ-1:0] wait_hit;

  rr_select #(.NREQ(NREQ), .QWID(QWID)) u_rr_select (
    .vld    (req_vld),
    .ptr    (rr_ptr),
    .winner (sel_winner),
    .any    (sel_any)
  );

  // Once a packet has started, only its owner may push until its last beat.
  assign winner  = (state == BURST) ? owner : sel_winner;
  assign win_vld = (state == BURST) ? req_vld[owner] : sel_any;
  assign accept  = win_vld & ~fifo_full & ~rst;

  assign fifo_push   = accept;
  assign req_rdy     = accept ? NREQ'(onehot(int'(winner))) : '0;
  assign fifo_data   = req_data[int'(winner)*WIDTH +: WIDTH];
  assign fifo_qid    = winner;
  assign busy        = (state == BURST);
  assign prop_signal = ~starve;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (req_last[winner]) begin
              rr_ptr <= winner + QWID'(1);
            end else begin
              state <= BURST;
              owner <= winner;
            end
          end
        end
        BURST: begin
          if (accept && req_last[owner]) begin
            state  <= IDLE;
            rr_ptr <= owner + QWID'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Wait counters keep running through fifo_full stalls; they saturate at MAX_WAIT.
  for (genvar i = 0; i < NREQ; i++) begin : g_wait
    logic [WAITW-1:0] cnt;

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
      end else if (req_vld[i] && !req_rdy[i]) begin
        if (cnt != WAITW'(MAX_WAIT)) cnt <= cnt + WAITW'(1);
      end else begin
        cnt <= '0;
      end
    end

    assign wait_hit[i] = (cnt == WAITW'(MAX_WAIT));
  end

  always_ff @(posedge clk) begin
    if (rst) starve <= 1'b0;
    else if (|wait_hit) starve <= 1'b1;
  end

endmodule

// File: tb/tb_fifo_rr_push_arbiter.sv
// Directed bench for fifo_rr_push_arbiter: requester models drive packets,
// a scoreboard queue holds the expected push order and a monitor checks each push.
module tb_fifo_rr_push_arbiter;

  localparam int WIDTH    = 8;
  localparam int QWID     = 2;
  localparam int NREQ     = 4;
  localparam int MAX_WAIT = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_vld;
  logic [NREQ-1:0]       req_last;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_rdy;
  logic                  fifo_full;
  logic                  fifo_push;
  logic [WIDTH-1:0]      fifo_data;
  logic [QWID-1:0]       fifo_qid;
  logic                  busy;
  logic                  prop_signal;

  fifo_rr_push_arbiter #(.WIDTH(WIDTH), .QWID(QWID), .MAX_WAIT(MAX_WAIT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_vld     (req_vld),
    .req_last    (req_last),
    .req_data    (req_data),
    .req_rdy     (req_rdy),
    .fifo_full   (fifo_full),
    .fifo_push   (fifo_push),
    .fifo_data   (fifo_data),
    .fifo_qid    (fifo_qid),
    .busy        (busy),
    .prop_signal (prop_signal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [QWID-1:0]  qid;
    logic [WIDTH-1:0] data;
  } beat_t;

  int    errors = 0;
  int    checks = 0;
  int    push_count = 0;
  beat_t exp_q[$];
  beat_t mon_e;

  int rem[NREQ];
  int pkts[NREQ];
  int size[NREQ];
  int beat_no[NREQ];

  logic [NREQ-1:0] rdy_s;
  logic            push_s;
  logic            busy_s;
  logic            prop_s;
  logic [QWID-1:0] qid_s;

  function automatic logic [WIDTH-1:0] mk_data(input int id, input int beat);
    return WIDTH'((id << 6) | (beat & 63));
  endfunction

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NREQ; i++) if (rem[i] > 0) n++;
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_vld[i]                = (rem[i] > 0);
      req_last[i]               = (rem[i] == 1);
      req_data[i*WIDTH +: WIDTH] = mk_data(i, beat_no[i]);
    end
  endtask

  task automatic applyStimulus(input int id, input int nbeats, input int npkts);
    size[id]    = nbeats;
    pkts[id]    = npkts;
    rem[id]     = nbeats;
    beat_no[id] = 0;
    drive();
  endtask

  task automatic expectBeat(input int id, input int beat);
    beat_t b;
    b.qid  = QWID'(id);
    b.data = mk_data(id, beat);
    exp_q.push_back(b);
  endtask

  // One clock cycle: snapshot outputs mid-cycle, then let requesters react to the handshake.
  task automatic tick();
    @(negedge clk);
    rdy_s  = req_rdy;
    push_s = fifo_push;
    busy_s = busy;
    prop_s = prop_signal;
    qid_s  = fifo_qid;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (rdy_s[i] && rem[i] > 0) begin
        beat_no[i]++;
        rem[i]--;
        if (rem[i] == 0 && pkts[i] > 1) begin
          pkts[i]--;
          rem[i] = size[i];
        end else if (rem[i] == 0) begin
          pkts[i] = 0;
        end
      end
    end
    drive();
  endtask

  task automatic waitIdle(input int max_cycles, input string name);
    int n = 0;
    while (pending() > 0 && n < max_cycles) begin
      tick();
      n++;
    end
    checkOutput(name, pending(), 0);
  endtask

  always @(negedge clk) begin
    if (fifo_push === 1'b1) begin
      push_count++;
      checkOutput("push_while_full", {31'd0, fifo_full}, 0);
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_push_qid", {30'd0, fifo_qid}, 32'hffff_ffff);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("push_qid", {30'd0, fifo_qid}, {30'd0, mon_e.qid});
        checkOutput("push_data", {24'd0, fifo_data}, {24'd0, mon_e.data});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int p0;
    rst       = 1'b1;
    fifo_full = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = 0; pkts[i] = 0; size[i] = 0; beat_no[i] = 0;
    end
    drive();
    @(posedge clk);
    #1;

    // Reset state
    tick();
    checkOutput("rst_req_rdy", {28'd0, rdy_s}, 0);
    checkOutput("rst_push", {31'd0, push_s}, 0);
    checkOutput("rst_busy", {31'd0, busy_s}, 0);
    checkOutput("rst_prop", {31'd0, prop_s}, 1);
    rst = 1'b0;
    tick();
    checkOutput("idle_push", {31'd0, push_s}, 0);
    checkOutput("idle_prop", {31'd0, prop_s}, 1);

    // Test 1: all requesters, single-beat packets, rotate every cycle
    $display("[TB] test 1: round robin single beats");
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++) expectBeat(i, r);
    for (int i = 0; i < NREQ; i++) applyStimulus(i, 1, 2);
    p0 = push_count;
    for (int k = 0; k < 8; k++) begin
      tick();
      checkOutput($sformatf("t1_push_c%0d", k), {31'd0, push_s}, 1);
    end
    checkOutput("t1_push_count", push_count - p0, 8);
    checkOutput("t1_drained", pending(), 0);

    // Test 2: req0 3-beat packet holds grant while req1 waits
    $display("[TB] test 2: burst holds grant");
    expectBeat(0, 0); expectBeat(0, 1); expectBeat(0, 2); expectBeat(1, 0);
    applyStimulus(0, 3, 1);
    applyStimulus(1, 1, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput($sformatf("t2_rdy_c%0d", k), {28'd0, rdy_s}, 32'h1);
      if (k == 1) checkOutput("t2_busy", {31'd0, busy_s}, 1);
    end
    tick();
    checkOutput("t2_rdy_req1", {28'd0, rdy_s}, 32'h2);

    // Test 3: fifo_full stall mid-burst
    $display("[TB] test 3: full stall mid-burst");
    for (int b = 0; b < 4; b++) expectBeat(2, b);
    expectBeat(3, 0);
    applyStimulus(2, 4, 1);
    applyStimulus(3, 1, 1);
    tick();
    fifo_full = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checkOutput($sformatf("t3_stall_push_c%0d", k), {31'd0, push_s}, 0);
      checkOutput($sformatf("t3_stall_rdy_c%0d", k), {28'd0, rdy_s}, 0);
      checkOutput($sformatf("t3_stall_busy_c%0d", k), {31'd0, busy_s}, 1);
    end
    fifo_full = 1'b0;
    tick();
    checkOutput("t3_resume_push", {31'd0, push_s}, 1);
    checkOutput("t3_resume_qid", {30'd0, qid_s}, 2);
    waitIdle(10, "t3_timeout");

    // Test 6: lone req3 wins immediately, then pointer wraps to 0
    $display("[TB] test 6: lone high requester and wrap");
    expectBeat(3, 0); expectBeat(3, 1);
    applyStimulus(3, 2, 1);
    tick();
    checkOutput("t6_rdy", {28'd0, rdy_s}, 32'h8);
    tick();
    expectBeat(1, 0); expectBeat(3, 0);
    applyStimulus(1, 1, 1);
    applyStimulus(3, 1, 1);
    tick();
    checkOutput("t6_wrap_qid_a", {30'd0, qid_s}, 1);
    tick();
    checkOutput("t6_wrap_qid_b", {30'd0, qid_s}, 3);

    // Test 4: req2 starved behind a 20-beat req1 packet
    $display("[TB] test 4: starvation watchdog");
    for (int b = 0; b < 20; b++) expectBeat(1, b);
    expectBeat(2, 0);
    applyStimulus(1, 20, 1);
    applyStimulus(2, 1, 1);
    for (int k = 0; k <= 20; k++) begin
      tick();
      if (k == 0)  checkOutput("t4_prop_start", {31'd0, prop_s}, 1);
      if (k == 16) checkOutput("t4_prop_c16", {31'd0, prop_s}, 1);
      if (k == 17) checkOutput("t4_prop_c17", {31'd0, prop_s}, 0);
      if (k == 20) checkOutput("t4_req2_qid", {30'd0, qid_s}, 2);
    end
    tick();
    checkOutput("t4_prop_sticky", {31'd0, prop_s}, 0);

    // Test 5: reset on second beat of a 4-beat packet
    $display("[TB] test 5: reset mid-packet");
    expectBeat(0, 0);
    applyStimulus(0, 4, 1);
    tick();
    rst = 1'b1;
    tick();
    checkOutput("t5_rst_push", {31'd0, push_s}, 0);
    checkOutput("t5_rst_rdy", {28'd0, rdy_s}, 0);
    rst = 1'b0;
    expectBeat(0, 1); expectBeat(0, 2); expectBeat(0, 3); expectBeat(3, 0);
    applyStimulus(3, 1, 1);
    tick();
    checkOutput("t5_busy_after_rst", {31'd0, busy_s}, 0);
    checkOutput("t5_qid_after_rst", {30'd0, qid_s}, 0);
    checkOutput("t5_prop_after_rst", {31'd0, prop_s}, 1);
    waitIdle(10, "t5_timeout");
    tick();

    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
